// File: rtl/gray_code_pkg.sv
// Shared Gray-code definitions.
// Provides the default geometry of the pipelined decoder and two reference
// functions. Both functions work on words up to MAX_WIDTH bits; narrower
// words are zero-extended and give the correct low bits back.
//   bin2gray : b ^ (b >> 1)
//   gray2bin : MSB-first prefix XOR
package gray_code_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_STAGES     = 4;
    localparam int MAX_WIDTH          = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ {1'b0, b[MAX_WIDTH-1:1]};
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary_segment.sv
// One slice of the Gray-to-binary prefix XOR (purely combinational).
// Ports:
//   gray_i  [SEG_WIDTH] : Gray bits of this slice, MSB first
//   carry_i             : last binary bit resolved above this slice (0 at the top)
//   bin_o   [SEG_WIDTH] : binary bits of this slice
//   carry_o             : lowest binary bit of this slice, seeds the next slice
module gray_to_binary_segment
    import gray_code_pkg::*;
#(
    parameter int SEG_WIDTH = 8
) (
    input  logic [SEG_WIDTH-1:0] gray_i,
    input  logic                 carry_i,
    output logic [SEG_WIDTH-1:0] bin_o,
    output logic                 carry_o
);

    // Running XOR from the slice MSB downwards, seeded with the incoming carry.
    always_comb begin
        logic acc;
        acc   = carry_i;
        bin_o = '0;
        for (int i = SEG_WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
        carry_o = acc;
    end

endmodule

// File: rtl/gray_to_binary_converter_pipelined.sv
// Pipelined Gray-to-binary decoder on a valid/ready stream.
// Stage k resolves binary bits [W-1-k*SEG : W-(k+1)*SEG]; a word leaves the
// last stage STAGES cycles after it was accepted when the pipe is not stalled.
// Ports:
//   Clock_In          : rising-edge clock
//   Reset_n_In        : asynchronous active-low reset
//   Enable_In         : 1 = operate, 0 = freeze pipeline and tri-state data out
//   Gray_Valid_In     : input word valid
//   Gray_Ready_Out    : input word can be accepted this cycle
//   Gray_Data_In      : Gray-coded input word
//   Binary_Valid_Out  : output word valid
//   Binary_Ready_In   : downstream accepts the output word
//   Binary_Data_Out   : decoded binary word, Z while disabled
module gray_to_binary_converter_pipelined
    import gray_code_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STAGES     = DEFAULT_STAGES
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Enable_In,
    input  logic                  Gray_Valid_In,
    output logic                  Gray_Ready_Out,
    input  logic [DATA_WIDTH-1:0] Gray_Data_In,
    output logic                  Binary_Valid_Out,
    input  logic                  Binary_Ready_In,
    output logic [DATA_WIDTH-1:0] Binary_Data_Out
);

    localparam int SEG_WIDTH = DATA_WIDTH / STAGES;

    // Per-stage state: full Gray word, binary bits resolved so far, carry.
    logic [STAGES-1:0]                 valid_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] gray_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] bin_q;
    logic [STAGES-1:0]                 carry_q;

    // Next-state values offered to each stage and its load/advance strobes.
    logic [STAGES-1:0][DATA_WIDTH-1:0] src_gray_s;
    logic [STAGES-1:0][DATA_WIDTH-1:0] src_bin_s;
    logic [STAGES-1:0]                 src_carry_s;
    logic [STAGES-1:0][DATA_WIDTH-1:0] bin_d;
    logic [STAGES-1:0]                 carry_d;
    logic [STAGES-1:0]                 adv_s;
    logic [STAGES-1:0]                 load_s;
    logic                              gray_ready_s;
    logic                              in_xfer_s;

    // Ready chain from the output back to the input: a stage may pass its word
    // on when the stage below is empty or is itself passing its word on.
    always_comb begin
        logic room;
        adv_s = '0;
        room  = Binary_Ready_In;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv_s[k] = valid_q[k] & room & Enable_In;
            room     = ~valid_q[k] | adv_s[k];
        end
        gray_ready_s = Enable_In & room;
    end

    assign in_xfer_s = Gray_Valid_In & gray_ready_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = DATA_WIDTH - (k + 1) * SEG_WIDTH;

        logic [SEG_WIDTH-1:0]  seg_bin_s;
        logic [DATA_WIDTH-1:0] seg_ext_s;

        if (k == 0) begin : g_first
            assign src_gray_s[k]  = Gray_Data_In;
            assign src_bin_s[k]   = '0;
            assign src_carry_s[k] = 1'b0;
            assign load_s[k]      = in_xfer_s;
        end else begin : g_next
            assign src_gray_s[k]  = gray_q[k-1];
            assign src_bin_s[k]   = bin_q[k-1];
            assign src_carry_s[k] = carry_q[k-1];
            assign load_s[k]      = adv_s[k-1];
        end

        gray_to_binary_segment #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .gray_i  (src_gray_s[k][LO +: SEG_WIDTH]),
            .carry_i (src_carry_s[k]),
            .bin_o   (seg_bin_s),
            .carry_o (carry_d[k])
        );

        // Unresolved low bits are still zero, so OR-ing the new slice in suffices.
        assign seg_ext_s = DATA_WIDTH'(seg_bin_s) << LO;
        assign bin_d[k]  = src_bin_s[k] | seg_ext_s;
    end

    // Stage registers: a loading stage takes the new word even if it is also
    // handing its current word on in the same cycle, so continuous flow has no bubbles.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            valid_q <= '0;
            gray_q  <= '0;
            bin_q   <= '0;
            carry_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_s[k]) begin
                    valid_q[k] <= 1'b1;
                    gray_q[k]  <= src_gray_s[k];
                    bin_q[k]   <= bin_d[k];
                    carry_q[k] <= carry_d[k];
                end else if (adv_s[k]) begin
                    valid_q[k] <= 1'b0;
                end else begin
                    valid_q[k] <= valid_q[k];
                end
            end
        end
    end

    // The last stage's Gray copy and carry have no consumer.
    logic unused_s;
    assign unused_s = ^{gray_q[STAGES-1], carry_q[STAGES-1]};

    assign Gray_Ready_Out   = gray_ready_s;
    assign Binary_Valid_Out = valid_q[STAGES-1] & Enable_In;
    assign Binary_Data_Out  = Enable_In ? bin_q[STAGES-1] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_gray_to_binary_converter_pipelined.sv
// Self-checking bench for gray_to_binary_converter_pipelined.
// Main instance: DATA_WIDTH=32, STAGES=4. Four extra instances cover the
// STAGES=1/2/32 and DATA_WIDTH=8 geometries with exhaustive 8-bit Gray input.
module tb_gray_to_binary_converter_pipelined;
    import gray_code_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Main instance
    logic        m_vin = 1'b0;
    logic [31:0] m_din = 32'h0;
    logic        m_rin = 1'b0;
    wire         m_rdy;
    wire         m_vout;
    wire  [31:0] m_dout;

    // Geometry sweep instances share their stimulus
    logic        sw_vin = 1'b0;
    logic [31:0] sw_din = 32'h0;
    wire         s1_rdy, s1_vout, s2_rdy, s2_vout, s32_rdy, s32_vout, w8_rdy, w8_vout;
    wire  [31:0] s1_dout, s2_dout, s32_dout;
    wire  [7:0]  w8_dout;
    wire  [3:0]  sw_rdy  = {w8_rdy, s32_rdy, s2_rdy, s1_rdy};
    wire  [3:0]  sw_vout = {w8_vout, s32_vout, s2_vout, s1_vout};
    wire  [3:0][31:0] sw_dout = {{24'h0, w8_dout}, s32_dout, s2_dout, s1_dout};

    gray_to_binary_converter_pipelined #(.DATA_WIDTH(32), .STAGES(4)) dut (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en),
        .Gray_Valid_In(m_vin), .Gray_Ready_Out(m_rdy), .Gray_Data_In(m_din),
        .Binary_Valid_Out(m_vout), .Binary_Ready_In(m_rin), .Binary_Data_Out(m_dout));

    gray_to_binary_converter_pipelined #(.DATA_WIDTH(32), .STAGES(1)) u_s1 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en),
        .Gray_Valid_In(sw_vin), .Gray_Ready_Out(s1_rdy), .Gray_Data_In(sw_din),
        .Binary_Valid_Out(s1_vout), .Binary_Ready_In(1'b1), .Binary_Data_Out(s1_dout));

    gray_to_binary_converter_pipelined #(.DATA_WIDTH(32), .STAGES(2)) u_s2 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en),
        .Gray_Valid_In(sw_vin), .Gray_Ready_Out(s2_rdy), .Gray_Data_In(sw_din),
        .Binary_Valid_Out(s2_vout), .Binary_Ready_In(1'b1), .Binary_Data_Out(s2_dout));

    gray_to_binary_converter_pipelined #(.DATA_WIDTH(32), .STAGES(32)) u_s32 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en),
        .Gray_Valid_In(sw_vin), .Gray_Ready_Out(s32_rdy), .Gray_Data_In(sw_din),
        .Binary_Valid_Out(s32_vout), .Binary_Ready_In(1'b1), .Binary_Data_Out(s32_dout));

    gray_to_binary_converter_pipelined #(.DATA_WIDTH(8), .STAGES(4)) u_w8 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en),
        .Gray_Valid_In(sw_vin), .Gray_Ready_Out(w8_rdy), .Gray_Data_In(sw_din[7:0]),
        .Binary_Valid_Out(w8_vout), .Binary_Ready_In(1'b1), .Binary_Data_Out(w8_dout));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One cycle on the main instance: called at posedge+1, drives inputs,
    // samples at posedge+2, returns at the next posedge+1.
    task automatic cycle_io(input logic v, input logic [31:0] d, input logic r,
                            output logic acc_in, output logic ov, output logic [31:0] od,
                            output logic acc_out, output logic rdy);
        m_vin = v;
        m_din = d;
        m_rin = r;
        #1;
        rdy     = m_rdy;
        ov      = m_vout;
        od      = m_dout;
        acc_in  = v & m_rdy;
        acc_out = m_vout & r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; m_vin = 1'b0; m_rin = 1'b1; sw_vin = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (m_vout !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", m_vout); end
        n_checks++;
        if (m_dout !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 00000000", m_dout); end
        n_checks++;
        if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", m_rdy); end
        en = 1'b0;
        #1;
        n_checks++;
        if (m_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_disabled: got %b, expected 0", m_rdy); end
        en = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] stim [4];
        logic [31:0] want [4];
        logic ai, ov, ao, rdy;
        logic [31:0] od;
        exp_t e;
        int idx, got, c;
        stim = '{32'h8000_0000, 32'hC000_0000, 32'h0000_0001, 32'h0000_0003};
        want = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
        idx = 0; got = 0; sb.delete();
        for (int t = 0; t < 20 && got < 4; t++) begin
            c = cyc;
            cycle_io(idx < 4, (idx < 4) ? stim[idx] : 32'h0, 1'b1, ai, ov, od, ao, rdy);
            if (ai) begin sb.push_back('{want[idx], c + 4}); idx++; end
            if (ao) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL basic_unexpected: got %h, expected no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL basic_decode: got %h at cycle %0d, expected %h at cycle %0d", od, c, e.data, e.cyc);
                    end
                end
            end
        end
        n_checks++;
        if (got != 4) begin n_fail++; $display("FAIL basic_count: got %0d outputs, expected 4", got); end
    endtask

    task automatic test_round_trip();
        localparam int N = 1001;
        logic ai, ov, ao, rdy;
        logic [31:0] od, cur_x, cur_g;
        exp_t e;
        int sent, got, c, drops;
        sent = 0; got = 0; drops = 0; sb.delete();
        cur_x = 32'h1234_5678; cur_g = 32'h1B2E_7D44;
        for (int t = 0; t < N + 40 && got < N; t++) begin
            c = cyc;
            cycle_io(sent < N, cur_g, 1'b1, ai, ov, od, ao, rdy);
            if (sent < N && rdy !== 1'b1) drops++;
            if (ai) begin
                sb.push_back('{cur_x, c + 4});
                sent++;
                cur_x = $urandom;
                cur_g = bin2gray(cur_x);
            end
            if (ao) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL roundtrip_unexpected: got %h, expected no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL roundtrip_decode: got %h at cycle %0d, expected %h at cycle %0d", od, c, e.data, e.cyc);
                    end
                end
            end
        end
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL roundtrip_count: got %0d outputs, expected %0d", got, N); end
        n_checks++;
        if (drops != 0) begin n_fail++; $display("FAIL roundtrip_ready: ready low in %0d cycles, expected 0", drops); end
    endtask

    task automatic test_backpressure();
        logic ai, ov, ao, rdy, pending;
        logic [31:0] od;
        exp_t e;
        int got, c;
        sb.delete();
        for (int i = 1; i <= 4; i++) begin
            c = cyc;
            cycle_io(1'b1, bin2gray(32'(i)), 1'b0, ai, ov, od, ao, rdy);
            n_checks++;
            if (!ai) begin n_fail++; $display("FAIL bp_fill: word %0d not accepted, expected accepted", i); end
            else sb.push_back('{32'(i), c + 4});
        end
        for (int t = 0; t < 3; t++) begin
            cycle_io(1'b1, bin2gray(32'd5), 1'b0, ai, ov, od, ao, rdy);
            n_checks++;
            if (rdy !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, expected 0 with pipe full", rdy); end
            n_checks++;
            if (ov !== 1'b1 || od !== 32'h1) begin
                n_fail++; $display("FAIL bp_hold: got valid %b data %h, expected valid 1 data 00000001", ov, od);
            end
        end
        pending = 1'b1; got = 0;
        for (int t = 0; t < 20 && got < 5; t++) begin
            c = cyc;
            cycle_io(pending, bin2gray(32'd5), 1'b1, ai, ov, od, ao, rdy);
            if (ai) begin sb.push_back('{32'd5, c + 4}); pending = 1'b0; end
            if (ao) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL bp_unexpected: got %h, expected no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data) begin n_fail++; $display("FAIL bp_drain: got %h, expected %h", od, e.data); end
                end
            end
        end
        n_checks++;
        if (got != 5) begin n_fail++; $display("FAIL bp_count: got %0d outputs, expected 5", got); end
    endtask

    task automatic test_enable_gating();
        localparam int N = 12;
        logic ai, ov, ao, rdy;
        logic [31:0] od;
        exp_t e;
        int sent, got;
        sent = 0; got = 0; sb.delete();
        for (int t = 0; t < 80 && got < N; t++) begin
            en = !(t >= 6 && t < 11);
            cycle_io(sent < N, bin2gray(32'hA5A5_0000 + 32'(sent)), 1'b1, ai, ov, od, ao, rdy);
            if (!en) begin
                // A released bus reads all-Z, or all-0 on a two-state simulator.
                n_checks++;
                if (od !== 32'hzzzz_zzzz && od !== 32'h0) begin n_fail++; $display("FAIL en_data_z: got %h, expected Z", od); end
                n_checks++;
                if (ov !== 1'b0) begin n_fail++; $display("FAIL en_valid: got %b, expected 0", ov); end
                n_checks++;
                if (rdy !== 1'b0) begin n_fail++; $display("FAIL en_ready: got %b, expected 0", rdy); end
            end
            if (ai) begin sb.push_back('{32'hA5A5_0000 + 32'(sent), 0}); sent++; end
            if (ao) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL en_unexpected: got %h, expected no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data) begin n_fail++; $display("FAIL en_resume: got %h, expected %h", od, e.data); end
                end
            end
        end
        en = 1'b1;
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL en_count: got %0d outputs, expected %0d", got, N); end
    endtask

    task automatic test_reset_mid();
        logic ai, ov, ao, rdy, pending;
        logic [31:0] od;
        int c, c_in, got, ghosts;
        for (int i = 0; i < 3; i++) begin
            cycle_io(1'b1, bin2gray(32'd7 + 32'(i)), 1'b1, ai, ov, od, ao, rdy);
        end
        cycle_io(1'b0, 32'h0, 1'b1, ai, ov, od, ao, rdy);
        m_vin = 1'b0;
        #1;
        n_checks++;
        if (m_vout !== 1'b1) begin n_fail++; $display("FAIL rst_inflight: got valid %b, expected 1 before reset", m_vout); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_vout !== 1'b0) begin n_fail++; $display("FAIL rst_async: got valid %b, expected 0 right after reset", m_vout); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ghosts = 0;
        for (int t = 0; t < 8; t++) begin
            cycle_io(1'b0, 32'h0, 1'b1, ai, ov, od, ao, rdy);
            if (ov !== 1'b0) ghosts++;
        end
        n_checks++;
        if (ghosts != 0) begin n_fail++; $display("FAIL rst_discard: got %0d stale outputs, expected 0", ghosts); end
        pending = 1'b1; got = 0; c_in = 0;
        for (int t = 0; t < 12 && got == 0; t++) begin
            c = cyc;
            cycle_io(pending, 32'h0000_0003, 1'b1, ai, ov, od, ao, rdy);
            if (ai) begin c_in = c; pending = 1'b0; end
            if (ao) begin
                got++;
                n_checks++;
                if (od !== 32'h2 || c != c_in + 4) begin
                    n_fail++;
                    $display("FAIL rst_after: got %h at cycle %0d, expected 00000002 at cycle %0d", od, c, c_in + 4);
                end
            end
        end
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL rst_after_count: got %0d outputs, expected 1", got); end
    endtask

    task automatic test_param_sweep();
        int lat [4];
        exp_t q0[$], q1[$], q2[$], q3[$];
        exp_t e;
        logic [3:0] v_s, r_s;
        logic [3:0][31:0] d_s;
        int c, bad_ready, got;
        lat = '{1, 2, 32, 4};
        bad_ready = 0; got = 0;
        for (int t = 0; t < 256 + 36; t++) begin
            c = cyc;
            sw_vin = (t < 256);
            sw_din = (t < 256) ? bin2gray(32'(t)) : 32'h0;
            #1;
            v_s = sw_vout; d_s = sw_dout; r_s = sw_rdy;
            if (t < 256) begin
                if (r_s !== 4'hF) bad_ready++;
                if (r_s[0]) q0.push_back('{32'(t), c + lat[0]});
                if (r_s[1]) q1.push_back('{32'(t), c + lat[1]});
                if (r_s[2]) q2.push_back('{32'(t), c + lat[2]});
                if (r_s[3]) q3.push_back('{32'(t), c + lat[3]});
            end
            for (int i = 0; i < 4; i++) begin
                if (v_s[i]) begin
                    got++;
                    n_checks++;
                    case (i)
                        0:       e = (q0.size() > 0) ? q0.pop_front() : '{32'hDEAD_BEEF, -1};
                        1:       e = (q1.size() > 0) ? q1.pop_front() : '{32'hDEAD_BEEF, -1};
                        2:       e = (q2.size() > 0) ? q2.pop_front() : '{32'hDEAD_BEEF, -1};
                        default: e = (q3.size() > 0) ? q3.pop_front() : '{32'hDEAD_BEEF, -1};
                    endcase
                    if (d_s[i] !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL sweep_decode: instance %0d got %h at cycle %0d, expected %h at cycle %0d",
                                 i, d_s[i], c, e.data, e.cyc);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        sw_vin = 1'b0;
        n_checks++;
        if (bad_ready != 0) begin n_fail++; $display("FAIL sweep_ready: ready low in %0d cycles, expected 0", bad_ready); end
        n_checks++;
        if (got != 4 * 256) begin n_fail++; $display("FAIL sweep_count: got %0d outputs, expected %0d", got, 4 * 256); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_trip();
        test_backpressure();
        test_enable_gating();
        test_reset_mid();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
